// File: rtl/h75_pixel_fetch_if.sv
// -----------------------------------------------------------------------------
// h75_pixel_fetch_if
// Purpose : write / bank-swap control bus of the HUB75 pixel fetch block.
//           The master (software/DMA side) pushes 24-bit RGB pixels into the
//           back bank and requests bank swaps; the slave (h75_pixel_fetch)
//           reports handshake and swap status.
// Signals :
//   wr_valid     master->slave  write request
//   wr_ready     slave->master  write accepted when wr_valid & wr_ready
//   wr_addr      master->slave  {y[Y_W:0], x}; y[Y_W]=0 top half, 1 bottom half
//   wr_data      master->slave  {R,G,B}, CH_W bits each
//   swap_req     master->slave  bank swap request (pulse)
//   swap_pending slave->master  swap requested, waiting for frame_sync edge
//   swap_ack     slave->master  one-cycle pulse when the swap executes
//   disp_bank    slave->master  bank currently being displayed
// -----------------------------------------------------------------------------
interface h75_pixel_fetch_if #(
    parameter int X_W  = 9,
    parameter int Y_W  = 5,
    parameter int CH_W = 8
);
    logic                 wr_valid;
    logic                 wr_ready;
    logic [Y_W+X_W:0]     wr_addr;
    logic [3*CH_W-1:0]    wr_data;
    logic                 swap_req;
    logic                 swap_pending;
    logic                 swap_ack;
    logic                 disp_bank;

    modport master (
        output wr_valid, wr_addr, wr_data, swap_req,
        input  wr_ready, swap_pending, swap_ack, disp_bank
    );

    modport slave (
        input  wr_valid, wr_addr, wr_data, swap_req,
        output wr_ready, swap_pending, swap_ack, disp_bank
    );
endinterface

// File: rtl/h75_pixel_fetch.sv
// -----------------------------------------------------------------------------
// h75_pixel_fetch
// Purpose : double-buffered frame store and bit-plane extractor for the HUB75
//           output path. Pixels are written into the back bank; the timing
//           generator reads the display bank and gets one bit per colour for
//           the top and bottom half rows. Bank swaps wait for a frame_sync
//           rising edge so a frame is never torn.
// Ports   :
//   clk          system clock
//   reset        asynchronous active-high reset
//   i_plane      bit plane being scanned (selects channel bit)
//   i_rd_addr    {row, x} read address from the timing generator
//   i_frame_sync frame start marker
//   o_rgb0       {R,G,B} bit of the top-half row, 2 cycles after the read
//   o_rgb1       {R,G,B} bit of the bottom-half row, 2 cycles after the read
//   bus          write / swap control bus (h75_pixel_fetch_if, slave side)
// Option  : define H75_GAMMA_EN to pass every channel through a gamma-2.2 ROM
//           before storage (adds one write pipeline stage).
// -----------------------------------------------------------------------------
module h75_pixel_fetch #(
    parameter int X_W  = 9,
    parameter int Y_W  = 5,
    parameter int CH_W = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [2:0]           i_plane,
    input  logic [X_W+Y_W-1:0]   i_rd_addr,
    input  logic                 i_frame_sync,
    output logic [2:0]           o_rgb0,
    output logic [2:0]           o_rgb1,
    h75_pixel_fetch_if.slave     bus
);
    localparam int AW    = 1 + Y_W + X_W;   // {bank, y, x}
    localparam int DW    = 3 * CH_W;
    localparam int DEPTH = 2 ** AW;

    genvar gi;

    // ---------------------------------------------------------------- swap FSM
    typedef enum logic {S_IDLE, S_PENDING} state_t;

    state_t r_state;
    state_t w_state_next;
    logic   r_disp_bank;
    logic   r_swap_ack;
    logic   r_fs_prev;
    logic   w_fs_rise;
    logic   w_swap_exec;

    assign w_fs_rise = i_frame_sync & ~r_fs_prev;

    // A frame_sync edge seen while still IDLE does not count: the swap waits
    // for the next edge, which keeps a whole frame on one bank.
    always_comb begin
        w_state_next = r_state;
        w_swap_exec  = 1'b0;
        case (r_state)
            S_IDLE:    if (bus.swap_req) w_state_next = S_PENDING;
            S_PENDING: if (w_fs_rise) begin
                w_swap_exec  = 1'b1;
                w_state_next = S_IDLE;
            end
            default:   w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_disp_bank <= 1'b0;
            r_swap_ack  <= 1'b0;
            r_fs_prev   <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_fs_prev  <= i_frame_sync;
            r_swap_ack <= w_swap_exec;
            if (w_swap_exec)
                r_disp_bank <= ~r_disp_bank;
        end
    end

    assign bus.swap_pending = (r_state == S_PENDING);
    assign bus.swap_ack     = r_swap_ack;
    assign bus.disp_bank    = r_disp_bank;

`ifdef H75_GAMMA_EN
    // Also hold off for the swap-ack cycle so the word still inside the gamma
    // stage is never overtaken by a fresh write aimed at the new back bank.
    assign bus.wr_ready = (r_state == S_IDLE) && !r_swap_ack;
`else
    assign bus.wr_ready = (r_state == S_IDLE);
`endif

    // -------------------------------------------------------------- write path
    logic          w_wr_fire;
    logic          r_wr_en;
    logic          r_wr_bot;
    logic [AW-1:0] r_wr_addr;
    logic [DW-1:0] r_wr_data;

    assign w_wr_fire = bus.wr_valid & bus.wr_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_wr_en <= 1'b0;
        else       r_wr_en <= w_wr_fire;
    end

    // The target bank is frozen at acceptance, so a write taken alongside a
    // swap request always completes into the old back bank.
    always_ff @(posedge clk) begin
        if (w_wr_fire) begin
            r_wr_bot  <= bus.wr_addr[Y_W+X_W];
            r_wr_addr <= {~r_disp_bank, bus.wr_addr[Y_W+X_W-1:0]};
            r_wr_data <= bus.wr_data;
        end
    end

    logic          w_mem_we;
    logic          w_mem_bot;
    logic [AW-1:0] w_mem_addr;
    logic [DW-1:0] w_mem_data;

`ifdef H75_GAMMA_EN
    // out = round(255 * (in/255)^2.2), evaluated at elaboration into a ROM.
    function automatic logic [CH_W-1:0] f_gamma(input int idx);
        real v;
        v = 255.0 * ((real'(idx) / 255.0) ** 2.2);
        return CH_W'($rtoi(v + 0.5));
    endfunction

    logic [CH_W-1:0] w_gamma_rom [256];
    for (gi = 0; gi < 256; gi++) begin : g_rom
        assign w_gamma_rom[gi] = f_gamma(gi);
    end

    logic            r_g_en;
    logic            r_g_bot;
    logic [AW-1:0]   r_g_addr;
    logic [CH_W-1:0] r_g_chan [3];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_g_en <= 1'b0;
        else       r_g_en <= r_wr_en;
    end

    always_ff @(posedge clk) begin
        r_g_bot  <= r_wr_bot;
        r_g_addr <= r_wr_addr;
    end

    // chan 0 = B, 1 = G, 2 = R
    for (gi = 0; gi < 3; gi++) begin : g_gamma
        always_ff @(posedge clk)
            r_g_chan[gi] <= w_gamma_rom[r_wr_data[gi*CH_W +: CH_W]];
    end

    assign w_mem_we   = r_g_en;
    assign w_mem_bot  = r_g_bot;
    assign w_mem_addr = r_g_addr;
    assign w_mem_data = {r_g_chan[2], r_g_chan[1], r_g_chan[0]};
`else
    assign w_mem_we   = r_wr_en;
    assign w_mem_bot  = r_wr_bot;
    assign w_mem_addr = r_wr_addr;
    assign w_mem_data = r_wr_data;
`endif

    // --------------------------------------------------- frame RAMs + extract
    logic [2:0] r_plane;

    always_ff @(posedge clk)
        r_plane <= i_plane;

    // g_ram[0] = top half, g_ram[1] = bottom half. Reads are unqualified and
    // run every cycle; the plane travels alongside the RAM read.
    for (gi = 0; gi < 2; gi++) begin : g_ram
        logic [DW-1:0]   r_mem [DEPTH];
        logic [DW-1:0]   r_q;
        logic [CH_W-1:0] w_r;
        logic [CH_W-1:0] w_g;
        logic [CH_W-1:0] w_b;
        logic [2:0]      r_rgb;

        always_ff @(posedge clk) begin
            if (w_mem_we && (w_mem_bot == 1'(gi)))
                r_mem[w_mem_addr] <= w_mem_data;
            r_q <= r_mem[{r_disp_bank, i_rd_addr}];
        end

        assign w_r = r_q[2*CH_W +: CH_W];
        assign w_g = r_q[CH_W   +: CH_W];
        assign w_b = r_q[0      +: CH_W];

        always_ff @(posedge clk or posedge reset) begin
            if (reset) r_rgb <= 3'b000;
            else       r_rgb <= {w_r[r_plane], w_g[r_plane], w_b[r_plane]};
        end
    end

    assign o_rgb0 = g_ram[0].r_rgb;
    assign o_rgb1 = g_ram[1].r_rgb;
endmodule

// File: tb/tb_h75_pixel_fetch.sv
// -----------------------------------------------------------------------------
// tb_h75_pixel_fetch
// Directed bench for h75_pixel_fetch. Reads push their expected rgb0/rgb1 into
// a scoreboard queue; a clocked checker pops them two cycles later. Control
// outputs are checked inline. Inputs change on the falling edge; outputs are
// sampled 1 time unit after the rising edge or on the falling edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_h75_pixel_fetch;
    localparam int X_W  = 9;
    localparam int Y_W  = 5;
    localparam int CH_W = 8;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic [2:0]           plane = 3'd0;
    logic [X_W+Y_W-1:0]   rd_addr = '0;
    logic                 frame_sync = 1'b0;
    logic [2:0]           rgb0;
    logic [2:0]           rgb1;

    always #5 clk = ~clk;

    h75_pixel_fetch_if #(.X_W(X_W), .Y_W(Y_W), .CH_W(CH_W)) bus ();

    h75_pixel_fetch #(.X_W(X_W), .Y_W(Y_W), .CH_W(CH_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .i_plane      (plane),
        .i_rd_addr    (rd_addr),
        .i_frame_sync (frame_sync),
        .o_rgb0       (rgb0),
        .o_rgb1       (rgb1),
        .bus          (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic       v;
        logic       m0;
        logic       m1;
        logic [2:0] e0;
        logic [2:0] e1;
        string      tag;
    } exp_t;

    exp_t cur;
    exp_t sb[$];
    exp_t popped;

    task automatic check(input string tag, input logic [23:0] obs, input logic [23:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: entry captured at the edge that registers the read is due
    // on the output one edge later.
    always @(posedge clk) begin
        if (reset) begin
            sb.delete();
        end else begin
            sb.push_back(cur);
            #1;
            if (sb.size() >= 2) begin
                popped = sb.pop_front();
                if (popped.v) begin
                    $display("read %s: rgb0=%b rgb1=%b", popped.tag, rgb0, rgb1);
                    if (popped.m0) check({popped.tag, "/rgb0"}, 24'(rgb0), 24'(popped.e0));
                    if (popped.m1) check({popped.tag, "/rgb1"}, 24'(rgb1), 24'(popped.e1));
                end
            end
        end
    end

    task automatic wr(input logic [Y_W:0] y, input logic [X_W-1:0] x, input logic [23:0] d);
        @(negedge clk);
        bus.wr_valid = 1'b1;
        bus.wr_addr  = {y, x};
        bus.wr_data  = d;
        $display("write y=%0d x=%0d data=%06h", y, x, d);
        check("wr_ready", 24'(bus.wr_ready), 24'd1);
        @(negedge clk);
        bus.wr_valid = 1'b0;
    endtask

    task automatic rd(input logic [Y_W-1:0] row, input logic [X_W-1:0] x, input logic [2:0] p,
                      input logic m0, input logic [2:0] e0, input logic m1, input logic [2:0] e1,
                      input string tag);
        @(negedge clk);
        rd_addr = {row, x};
        plane   = p;
        cur.v = 1'b1; cur.m0 = m0; cur.e0 = e0; cur.m1 = m1; cur.e1 = e1; cur.tag = tag;
    endtask

    task automatic drain();
        @(negedge clk);
        cur.v = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic req_swap();
        @(negedge clk);
        bus.swap_req = 1'b1;
        @(negedge clk);
        bus.swap_req = 1'b0;
        $display("swap_req issued");
        check("swap_pending", 24'(bus.swap_pending), 24'd1);
        check("wr_ready_pend", 24'(bus.wr_ready), 24'd0);
    endtask

    // Pulse frame_sync for one cycle and check the swap executes with it.
    task automatic fs_pulse_swap(input logic bank_after);
        @(negedge clk);
        frame_sync = 1'b1;
        @(negedge clk);
        frame_sync = 1'b0;
        $display("frame_sync: swap_ack=%b disp_bank=%b", bus.swap_ack, bus.disp_bank);
        check("swap_ack", 24'(bus.swap_ack), 24'd1);
        check("disp_bank", 24'(bus.disp_bank), 24'(bank_after));
        @(negedge clk);
        check("swap_ack_end", 24'(bus.swap_ack), 24'd0);
        check("pending_end", 24'(bus.swap_pending), 24'd0);
    endtask

    logic [2:0] t1_exp;
    logic [2:0] t2_exp [3];
    int         ack_cnt;

    initial begin
        cur.v = 1'b0; cur.m0 = 1'b0; cur.m1 = 1'b0; cur.e0 = '0; cur.e1 = '0; cur.tag = "";
        bus.wr_valid = 1'b0;
        bus.wr_addr  = '0;
        bus.wr_data  = '0;
        bus.swap_req = 1'b0;
`ifdef H75_GAMMA_EN
        t1_exp = 3'b100;
        t2_exp[0] = 3'b000; t2_exp[1] = 3'b000; t2_exp[2] = 3'b000;
`else
        t1_exp = 3'b101;
        t2_exp[0] = 3'b001; t2_exp[1] = 3'b010; t2_exp[2] = 3'b100;
`endif

        // ---- reset state
        repeat (3) @(negedge clk);
        check("rst_rgb0", 24'(rgb0), 24'd0);
        check("rst_rgb1", 24'(rgb1), 24'd0);
        check("rst_pending", 24'(bus.swap_pending), 24'd0);
        check("rst_ack", 24'(bus.swap_ack), 24'd0);
        check("rst_disp_bank", 24'(bus.disp_bank), 24'd0);
        check("rst_wr_ready", 24'(bus.wr_ready), 24'd1);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // ---- 1: top pixel, plane 7
        wr(6'd0, 9'd5, 24'hFF_00_80);
        wr(6'd32, 9'd5, 24'h00_00_00);
        repeat (3) @(negedge clk);
        req_swap();
        fs_pulse_swap(1'b1);
        rd(5'd0, 9'd5, 3'd7, 1'b1, t1_exp, 1'b1, 3'b000, "t1_p7");
        drain();

        // ---- 2: bottom pixel, planes 2,1,0 back-to-back
        wr(6'd0, 9'd5, 24'h00_00_00);
        wr(6'd32, 9'd5, 24'h01_02_04);
        repeat (3) @(negedge clk);
        req_swap();
        fs_pulse_swap(1'b0);
        rd(5'd0, 9'd5, 3'd2, 1'b1, 3'b000, 1'b1, t2_exp[0], "t2_p2");
        rd(5'd0, 9'd5, 3'd1, 1'b1, 3'b000, 1'b1, t2_exp[1], "t2_p1");
        rd(5'd0, 9'd5, 3'd0, 1'b1, 3'b000, 1'b1, t2_exp[2], "t2_p0");
        drain();

        // ---- 3: swap held pending for 100 cycles
        req_swap();
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (i % 25 == 24) begin
                $display("pending cycle %0d: pending=%b wr_ready=%b bank=%b ack=%b",
                         i, bus.swap_pending, bus.wr_ready, bus.disp_bank, bus.swap_ack);
                check("t3_pending", 24'(bus.swap_pending), 24'd1);
                check("t3_wr_ready", 24'(bus.wr_ready), 24'd0);
                check("t3_disp_bank", 24'(bus.disp_bank), 24'd0);
                check("t3_ack", 24'(bus.swap_ack), 24'd0);
            end
        end
        fs_pulse_swap(1'b1);

        // ---- 4: two requests, two frame edges -> exactly one swap
        @(negedge clk); bus.swap_req = 1'b1;
        @(negedge clk); bus.swap_req = 1'b0;
        @(negedge clk); bus.swap_req = 1'b1;
        @(negedge clk); bus.swap_req = 1'b0;
        ack_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            frame_sync = (i == 1) || (i == 6);
            if (bus.swap_ack === 1'b1) ack_cnt++;
        end
        frame_sync = 1'b0;
        $display("double request: acks=%0d disp_bank=%b", ack_cnt, bus.disp_bank);
        check("t4_ack_count", 24'(ack_cnt), 24'd1);
        check("t4_disp_bank", 24'(bus.disp_bank), 24'd0);
        check("t4_pending", 24'(bus.swap_pending), 24'd0);

        // ---- 4b: request coincident with a frame edge waits for the next one
        @(negedge clk); bus.swap_req = 1'b1; frame_sync = 1'b1;
        @(negedge clk); bus.swap_req = 1'b0; frame_sync = 1'b0;
        @(negedge clk);
        $display("coincident request: pending=%b ack=%b", bus.swap_pending, bus.swap_ack);
        check("t4b_ack", 24'(bus.swap_ack), 24'd0);
        check("t4b_pending", 24'(bus.swap_pending), 24'd1);
        check("t4b_disp_bank", 24'(bus.disp_bank), 24'd0);
        fs_pulse_swap(1'b1);

        // ---- 5: zeros on display, ones in back bank, no mixing
        for (int h = 0; h < 2; h++)
            for (int r = 0; r < 2; r++)
                for (int x = 0; x < 2; x++)
                    wr(6'(h * 32 + r), 9'(x), 24'h000000);
        repeat (3) @(negedge clk);
        req_swap();
        fs_pulse_swap(1'b0);
        for (int h = 0; h < 2; h++)
            for (int r = 0; r < 2; r++)
                for (int x = 0; x < 2; x++)
                    wr(6'(h * 32 + r), 9'(x), 24'hFFFFFF);
        repeat (3) @(negedge clk);
        for (int r = 0; r < 2; r++)
            for (int x = 0; x < 2; x++)
                rd(5'(r), 9'(x), 3'd7, 1'b1, 3'b000, 1'b1, 3'b000, "t5_before");
        drain();
        req_swap();
        for (int r = 0; r < 2; r++)
            for (int x = 0; x < 2; x++)
                rd(5'(r), 9'(x), 3'(r * 2 + x + 3), 1'b1, 3'b000, 1'b1, 3'b000, "t5_pending");
        drain();
        fs_pulse_swap(1'b1);
        for (int r = 0; r < 2; r++)
            for (int x = 0; x < 2; x++)
                rd(5'(r), 9'(x), 3'(r * 2 + x + 3), 1'b1, 3'b111, 1'b1, 3'b111, "t5_after");
        drain();

        // ---- 6: reset while pending
        @(negedge clk);
        rd_addr = '0;
        plane   = 3'd7;
        repeat (3) @(negedge clk);
        check("t6_rgb0_pre", 24'(rgb0), 24'd7);
        req_swap();
        #2;
        reset = 1'b1;
        #1;
        $display("reset while pending: bank=%b pending=%b wr_ready=%b rgb0=%b rgb1=%b",
                 bus.disp_bank, bus.swap_pending, bus.wr_ready, rgb0, rgb1);
        check("t6_disp_bank", 24'(bus.disp_bank), 24'd0);
        check("t6_pending", 24'(bus.swap_pending), 24'd0);
        check("t6_wr_ready", 24'(bus.wr_ready), 24'd1);
        check("t6_rgb0", 24'(rgb0), 24'd0);
        check("t6_rgb1", 24'(rgb1), 24'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
